// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: round-robin arbiter sharing one LCD controller command port (start/done + settle delay) among NREQ requesters. Optional LCD_ARB_TIMEOUT_EN adds a WAIT timeout. Ports: clk, rst, req_valid/req_data/req_ready, lcd_start/lcd_data/lcd_rs/lcd_done, grant_id, busy, err_timeout.
module lcd_cmd_arbiter #(
  parameter int NREQ       = 2,
  parameter int DLY_CYCLES = 262143,
  parameter int DLY_W      = 18,
  parameter int TIMEOUT    = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [9*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                lcd_start,
  output logic [7:0]          lcd_data,
  output logic                lcd_rs,
  input  logic                lcd_done,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                err_timeout
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DLY} state_t;
  state_t state, state_nx;
  logic [2:0] rr_ptr, win;
  logic [8:0] win_data;
  logic [DLY_W-1:0] dly_cnt;
  logic any, accept, fin, tmo;
  int best_d, d;
  always_comb begin
    best_d = NREQ;
    d = 0;
    win = 3'd0;
    win_data = 9'd0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i >= int'(rr_ptr)) ? i - int'(rr_ptr) : i + NREQ - int'(rr_ptr);
      if (req_valid[i] && d < best_d) begin
        best_d = d;
        win = 3'(i);
        win_data = req_data[9*i +: 9];
      end
    end
    any = |req_valid;
    accept = (state == IDLE) && any && !rst;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) req_ready[i] = accept && (win == 3'(i));
  end
`ifdef LCD_ARB_TIMEOUT_EN
  logic [31:0] wcnt;
  assign tmo = (state == WAIT) && !lcd_done && (wcnt == 32'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      wcnt <= (state == WAIT) ? wcnt + 32'd1 : '0;
      err_timeout <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign err_timeout = 1'b0;
`endif
  assign fin = (state == WAIT) && (lcd_done || tmo);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = any ? START : IDLE;
      START: state_nx = WAIT;
      WAIT:  state_nx = fin ? ((DLY_CYCLES == 0) ? IDLE : DLY) : WAIT;
      DLY:   state_nx = (dly_cnt == DLY_W'(DLY_CYCLES - 1)) ? IDLE : DLY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      dly_cnt  <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
      grant_id <= '0;
    end else begin
      state   <= state_nx;
      dly_cnt <= (state == DLY) ? dly_cnt + 1'b1 : '0;
      if (accept) begin
        lcd_rs   <= win_data[8];
        lcd_data <= win_data[7:0];
        grant_id <= win;
        rr_ptr   <= (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
      end
    end
  end
  assign lcd_start = (state == START);
  assign busy = (state != IDLE);
endmodule
